// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle between the timing generator and the pixel source / VGA pins.
// The generator drives positions, syncs, data-enable and strobes; the consumer drives pix_en/en.
// Optional frame counter signal present only when VGA_TIMING_FCNT_EN is defined.
`timescale 1ns/1ps
interface vga_timing_gen_if #(
  parameter int CNT_W = 10
`ifdef VGA_TIMING_FCNT_EN
  , parameter int FCNT_W = 8
`endif
);
  logic             pix_en;
  logic             en;
  logic [CNT_W-1:0] hcnt;
  logic [CNT_W-1:0] vcnt;
  logic             hsync;
  logic             vsync;
  logic             de;
  logic             line_start;
  logic             frame_start;
`ifdef VGA_TIMING_FCNT_EN
  logic [FCNT_W-1:0] frame_cnt;

  modport master (
    input  pix_en, en,
    output hcnt, vcnt, hsync, vsync, de, line_start, frame_start, frame_cnt
  );
  modport slave (
    output pix_en, en,
    input  hcnt, vcnt, hsync, vsync, de, line_start, frame_start, frame_cnt
  );
`else
  modport master (
    input  pix_en, en,
    output hcnt, vcnt, hsync, vsync, de, line_start, frame_start
  );
  modport slave (
    output pix_en, en,
    input  hcnt, vcnt, hsync, vsync, de, line_start, frame_start
  );
`endif
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator on the system clock, advanced by a pixel-rate enable.
// Latency: syncs/de/strobes are registered from the next counter values, so they line up with hcnt/vcnt.
// No backpressure; en or pix_en low freezes position and outputs. Frame counter under VGA_TIMING_FCNT_EN.
`timescale 1ns/1ps
module vga_timing_gen #(
  parameter int CNT_W    = 10,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit H_POL    = 1'b0,
  parameter bit V_POL    = 1'b0
`ifdef VGA_TIMING_FCNT_EN
  , parameter int FCNT_W = 8
`endif
) (
  input  logic             clk,
  input  logic             rst,
  vga_timing_gen_if.master bus
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  // One extra bit on the compare constants so a sync window ending exactly at 2**CNT_W does not wrap.
  localparam int CW1     = CNT_W + 1;

  localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_TOTAL - 1);
  localparam logic [CW1-1:0]   H_ACT_X = CW1'(H_ACTIVE);
  localparam logic [CW1-1:0]   HS_BEG  = CW1'(H_ACTIVE + H_FP);
  localparam logic [CW1-1:0]   HS_END  = CW1'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW1-1:0]   V_ACT_X = CW1'(V_ACTIVE);
  localparam logic [CW1-1:0]   VS_BEG  = CW1'(V_ACTIVE + V_FP);
  localparam logic [CW1-1:0]   VS_END  = CW1'(V_ACTIVE + V_FP + V_SYNC);

  // Reject timings the counters cannot represent, and degenerate zero-width regions.
  if (H_TOTAL > 2**CNT_W) begin : g_chk_htotal
    $error("vga_timing_gen: H_TOTAL %0d exceeds 2**CNT_W", H_TOTAL);
  end
  if (V_TOTAL > 2**CNT_W) begin : g_chk_vtotal
    $error("vga_timing_gen: V_TOTAL %0d exceeds 2**CNT_W", V_TOTAL);
  end
  if (H_ACTIVE == 0 || H_SYNC == 0 || V_ACTIVE == 0 || V_SYNC == 0) begin : g_chk_zero
    $error("vga_timing_gen: active and sync widths must be non-zero");
  end

  logic             adv;
  logic             h_wrap;
  logic             v_wrap;
  logic [CNT_W-1:0] hcnt_nx;
  logic [CNT_W-1:0] vcnt_nx;
  logic             hs_act;
  logic             vs_act;
  logic             de_nx;

  logic [CNT_W-1:0] hcnt_q;
  logic [CNT_W-1:0] vcnt_q;
  logic             hsync_q;
  logic             vsync_q;
  logic             de_q;
  logic             line_start_q;
  logic             frame_start_q;

  assign adv = bus.en & bus.pix_en;

  // Next raster position (compare-to-total wrap) and the decode of that position.
  always_comb begin
    h_wrap  = (hcnt_q == H_LAST);
    v_wrap  = (vcnt_q == V_LAST);
    hcnt_nx = h_wrap ? '0 : hcnt_q + CNT_W'(1);
    vcnt_nx = vcnt_q;
    if (h_wrap) begin
      vcnt_nx = v_wrap ? '0 : vcnt_q + CNT_W'(1);
    end
    hs_act = ({1'b0, hcnt_nx} >= HS_BEG) && ({1'b0, hcnt_nx} < HS_END);
    vs_act = ({1'b0, vcnt_nx} >= VS_BEG) && ({1'b0, vcnt_nx} < VS_END);
    de_nx  = ({1'b0, hcnt_nx} < H_ACT_X) && ({1'b0, vcnt_nx} < V_ACT_X);
  end

  // Position and decoded outputs update together on each pixel tick; strobes last one clk.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hcnt_q        <= H_LAST;
      vcnt_q        <= V_LAST;
      hsync_q       <= ~H_POL;
      vsync_q       <= ~V_POL;
      de_q          <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      if (adv) begin
        hcnt_q        <= hcnt_nx;
        vcnt_q        <= vcnt_nx;
        hsync_q       <= hs_act ? H_POL : ~H_POL;
        vsync_q       <= vs_act ? V_POL : ~V_POL;
        de_q          <= de_nx;
        line_start_q  <= h_wrap;
        frame_start_q <= h_wrap & v_wrap;
      end
    end
  end

  assign bus.hcnt        = hcnt_q;
  assign bus.vcnt        = vcnt_q;
  assign bus.hsync       = hsync_q;
  assign bus.vsync       = vsync_q;
  assign bus.de          = de_q;
  assign bus.line_start  = line_start_q;
  assign bus.frame_start = frame_start_q;

`ifdef VGA_TIMING_FCNT_EN
  logic [FCNT_W-1:0] frame_cnt_q;

  // Count frames on the same edge that raises frame_start; wraps naturally at 2**FCNT_W.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_cnt_q <= '0;
    end else if (adv && h_wrap && v_wrap) begin
      frame_cnt_q <= frame_cnt_q + FCNT_W'(1);
    end
  end

  assign bus.frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen with a shrunken raster so whole frames fit in a short run.
// Timing under test: H 8/2/3/2 (total 15), V 4/1/2/2 (total 9), CNT_W=4, hsync active-low, vsync active-high.
// pix_en pulses every 4th clk; frame period is therefore 15*9*4 = 540 clk.
`timescale 1ns/1ps
module tb_vga_timing_gen;

  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   last_fs = -1;
`ifdef VGA_TIMING_FCNT_EN
  int   exp_fcnt = 0;
`endif

`ifdef VGA_TIMING_FCNT_EN
  vga_timing_gen_if #(.CNT_W(CNT_W), .FCNT_W(2)) bus ();
`else
  vga_timing_gen_if #(.CNT_W(CNT_W)) bus ();
`endif

  vga_timing_gen #(
    .CNT_W(CNT_W),
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .H_POL(1'b0), .V_POL(1'b1)
`ifdef VGA_TIMING_FCNT_EN
    , .FCNT_W(2)
`endif
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: run did not complete, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Three idle clocks then one pixel tick; expect the raster to land on (h,v).
  task automatic step(input int h, input int v);
    logic [31:0] hs_e, vs_e, de_e;
    @(posedge clk); #1;
    chk("line_start_clear", bus.line_start, 0);
    chk("frame_start_clear", bus.frame_start, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    bus.pix_en = 1'b1;
    @(posedge clk); #1;
    bus.pix_en = 1'b0;
    hs_e = (h >= 10 && h <= 12) ? 0 : 1;
    vs_e = (v >= 5 && v <= 6) ? 1 : 0;
    de_e = (h < 8 && v < 4) ? 1 : 0;
    chk($sformatf("hcnt@%0d,%0d", h, v), bus.hcnt, h);
    chk($sformatf("vcnt@%0d,%0d", h, v), bus.vcnt, v);
    chk($sformatf("hsync@%0d,%0d", h, v), bus.hsync, hs_e);
    chk($sformatf("vsync@%0d,%0d", h, v), bus.vsync, vs_e);
    chk($sformatf("de@%0d,%0d", h, v), bus.de, de_e);
    chk($sformatf("line_start@%0d,%0d", h, v), bus.line_start, (h == 0) ? 1 : 0);
    chk($sformatf("frame_start@%0d,%0d", h, v), bus.frame_start, (h == 0 && v == 0) ? 1 : 0);
    if (h == 0 && v == 0) begin
      if (last_fs >= 0) chk("frame_period", cyc - last_fs, 540);
      last_fs = cyc;
`ifdef VGA_TIMING_FCNT_EN
      exp_fcnt = (exp_fcnt + 1) % 4;
`endif
    end
`ifdef VGA_TIMING_FCNT_EN
    chk("frame_cnt", bus.frame_cnt, exp_fcnt);
`endif
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_hcnt"}, bus.hcnt, 14);
    chk({tag, "_vcnt"}, bus.vcnt, 8);
    chk({tag, "_hsync"}, bus.hsync, 1);
    chk({tag, "_vsync"}, bus.vsync, 0);
    chk({tag, "_de"}, bus.de, 0);
    chk({tag, "_line_start"}, bus.line_start, 0);
    chk({tag, "_frame_start"}, bus.frame_start, 0);
`ifdef VGA_TIMING_FCNT_EN
    chk({tag, "_frame_cnt"}, bus.frame_cnt, 0);
`endif
  endtask

  initial begin
    bus.pix_en = 1'b0;
    bus.en     = 1'b0;

    // Power-on reset.
    #2 rst = 1'b0;
    #1 chk_reset_state("reset");
    repeat (2) @(negedge clk);
    rst    = 1'b1;
    bus.en = 1'b1;

    // en without pix_en must not move the raster.
    repeat (2) @(posedge clk); #1;
    chk("no_tick_hcnt", bus.hcnt, 14);
    chk("no_tick_vcnt", bus.vcnt, 8);
    chk("no_tick_de", bus.de, 0);

    // Two full frames starting from the first advance at (0,0).
    for (int f = 0; f < 2; f++)
      for (int v = 0; v < 9; v++)
        for (int h = 0; h < 15; h++)
          step(h, v);

    // Third frame start (second period check), then walk to hcnt=5.
    for (int h = 0; h <= 5; h++) step(h, 0);

    // Drop en for 37 clk while pix_en keeps ticking.
    bus.en = 1'b0;
    for (int i = 0; i < 37; i++) begin
      @(negedge clk);
      bus.pix_en = (i % 4 == 3);
    end
    @(posedge clk); #1;
    bus.pix_en = 1'b0;
    chk("freeze_hcnt", bus.hcnt, 5);
    chk("freeze_vcnt", bus.vcnt, 0);
    chk("freeze_de", bus.de, 1);
    chk("freeze_hsync", bus.hsync, 1);
    chk("freeze_vsync", bus.vsync, 0);
    chk("freeze_line_start", bus.line_start, 0);
    bus.en = 1'b1;

    // Resume without skip, continue into the vsync region up to (13,6).
    for (int h = 6; h < 15; h++) step(h, 0);
    for (int v = 1; v <= 5; v++)
      for (int h = 0; h < 15; h++)
        step(h, v);
    for (int h = 0; h <= 13; h++) step(h, 6);

    // Asynchronous reset in the middle of a clock period.
    #3 rst = 1'b0;
    #1 chk_reset_state("midreset");
    repeat (2) @(negedge clk);
    rst     = 1'b1;
    last_fs = -1;
`ifdef VGA_TIMING_FCNT_EN
    exp_fcnt = 0;
`endif
    step(0, 0);
    step(1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
